// File: rtl/sum_every_n_pkg.sv
// sum_every_n_pkg: shared types and arithmetic helpers for the group-sum accumulator
package sum_every_n_pkg;

    typedef enum logic {S_IDLE, S_ACC} state_t;

    localparam int XW = 64;

    // Zero- or sign-extend the low iw bits of x to the full helper width
    function automatic logic [XW-1:0] ext_sample(input logic [XW-1:0] x, input int iw, input logic sgn);
        logic [XW-1:0] m;
        m = {XW{1'b1}} << iw;
        return (sgn && x[iw-1]) ? (x | m) : (x & ~m);
    endfunction

    // Clamp a requested group length into 1..n_max
    function automatic int n_eff(input int cfg, input int n_max);
        return (cfg == 0) ? 1 : (cfg > n_max) ? n_max : cfg;
    endfunction

endpackage

// File: rtl/sen_out_reg.sv
// sen_out_reg: single-entry valid/ready holding register for the emitted sum
module sen_out_reg #(
    parameter int OW = 11,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [OW-1:0] i_sum,
    input  logic [CW-1:0] i_cnt,
    input  logic          i_take,
    output logic          o_dval,
    output logic [OW-1:0] o,
    output logic [CW-1:0] o_cnt,
    output logic          o_free
);

    assign o_free = ~o_dval | i_take;

    // Load a new sum when emitted, otherwise drop valid once the consumer takes it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_dval <= 1'b0;
            o      <= '0;
            o_cnt  <= '0;
        end else if (i_load) begin
            o_dval <= 1'b1;
            o      <= i_sum;
            o_cnt  <= i_cnt;
        end else if (i_take) begin
            o_dval <= 1'b0;
        end
    end

endmodule

// File: rtl/sum_every_n.sv
// sum_every_n: sums each group of cfg_n accepted samples with flush and valid/ready on both sides
module sum_every_n
    import sum_every_n_pkg::*;
#(
    parameter int IW     = 8,
    parameter int N_MAX  = 8,
    parameter int SIGNED = 0,
    localparam int CW    = $clog2(N_MAX + 1),
    localparam int OW    = IW + $clog2(N_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] cfg_n,
    input  logic          i_flush,
    input  logic          i_dval,
    output logic          i_rdy,
    input  logic [IW-1:0] i,
    output logic          o_dval,
    input  logic          o_rdy,
    output logic [OW-1:0] o,
    output logic [CW-1:0] o_cnt
);

    state_t        r_state;
    logic [OW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_n;
    logic [OW-1:0] w_ext;
    logic [OW-1:0] w_sum;
    logic [CW-1:0] w_cnt;
    logic [CW-1:0] w_n_eff;
    logic          w_acc;
    logic          w_flush;
    logic          w_free;
    logic          w_close;

    assign i_rdy   = rst & w_free;
    assign w_acc   = i_dval & i_rdy;
    assign w_flush = i_flush & i_rdy;
    assign w_ext   = OW'(ext_sample(XW'(i), IW, SIGNED != 0));
    assign w_n_eff = CW'(n_eff(int'(cfg_n), N_MAX));

    // Running sum and count including this cycle's sample; the group closes on reaching its length or on flush
    always_comb begin
        w_sum   = (r_state == S_ACC ? r_acc : '0) + (w_acc ? w_ext : '0);
        w_cnt   = (r_state == S_ACC ? r_cnt : '0) + CW'(w_acc);
        w_close = w_acc ? (w_flush || w_cnt == (r_state == S_ACC ? r_n : w_n_eff))
                        : (w_flush && r_state == S_ACC);
    end

    // Group FSM: latch the length on the first sample, accumulate, and return to idle on close
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_n     <= '0;
        end else begin
            if (w_acc && r_state == S_IDLE)
                r_n <= w_n_eff;
            if (w_close) begin
                r_state <= S_IDLE;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else if (w_acc) begin
                r_state <= S_ACC;
                r_acc   <= w_sum;
                r_cnt   <= w_cnt;
            end
        end
    end

    sen_out_reg #(.OW(OW), .CW(CW)) u_out (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_close),
        .i_sum  (w_sum),
        .i_cnt  (w_cnt),
        .i_take (o_rdy),
        .o_dval (o_dval),
        .o      (o),
        .o_cnt  (o_cnt),
        .o_free (w_free)
    );

endmodule

// File: tb/tb_sum_every_n.sv
// tb_sum_every_n: scoreboard bench driving an unsigned and a signed instance with shared stimulus
module tb_sum_every_n;

    localparam int IW = 8, N_MAX = 8, CW = 4, OW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] cfg_n = '0;
    logic          i_flush = 1'b0, i_dval = 1'b0, o_rdy = 1'b1;
    logic [IW-1:0] i = '0;
    logic          rdy_u, rdy_s, dval_u, dval_s;
    logic [OW-1:0] o_u, o_s;
    logic [CW-1:0] cnt_u, cnt_s;
    logic          want_rdy = 1'b1;
    int            checks = 0, errors = 0;

    typedef struct packed {logic [OW-1:0] s; logic [CW-1:0] c;} exp_t;
    exp_t qu[$], qs[$];
    int   grp[$];
    int   n_lat = 1;

    sum_every_n #(.IW(IW), .N_MAX(N_MAX), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst), .cfg_n(cfg_n), .i_flush(i_flush), .i_dval(i_dval), .i_rdy(rdy_u),
        .i(i), .o_dval(dval_u), .o_rdy(o_rdy), .o(o_u), .o_cnt(cnt_u)
    );

    sum_every_n #(.IW(IW), .N_MAX(N_MAX), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .cfg_n(cfg_n), .i_flush(i_flush), .i_dval(i_dval), .i_rdy(rdy_s),
        .i(i), .o_dval(dval_s), .o_rdy(o_rdy), .o(o_s), .o_cnt(cnt_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int eff(input int c);
        return (c == 0) ? 1 : (c > N_MAX ? N_MAX : c);
    endfunction

    // Reference: close the current group and queue its unsigned and two's-complement sums
    task automatic emit();
        int us = 0, ss = 0;
        foreach (grp[k]) begin
            us += grp[k];
            ss += (grp[k] >= 128) ? grp[k] - 256 : grp[k];
        end
        qu.push_back({OW'(us), CW'(grp.size())});
        qs.push_back({OW'(ss), CW'(grp.size())});
        grp.delete();
    endtask

    // Drive one cycle of inputs at the falling edge, then judge the handshake just before the rising edge
    task automatic step(input logic [CW-1:0] c, input logic dv, input logic [IW-1:0] x,
                        input logic fl, output logic a);
        @(negedge clk);
        cfg_n = c; i_dval = dv; i = x; i_flush = fl; o_rdy = want_rdy;
        #4;
        a = dv & rdy_u;
        if (a) begin
            if (grp.size() == 0) n_lat = eff(int'(c));
            grp.push_back(int'(x));
            if (grp.size() == n_lat || fl) emit();
        end else if (fl && rdy_u && grp.size() != 0) begin
            emit();
        end
    endtask

    task automatic send(input logic [CW-1:0] c, input logic [IW-1:0] x);
        logic a;
        int   k;
        a = 1'b0;
        k = 0;
        while (!a && k < 100) begin
            step(c, 1'b1, x, 1'b0, a);
            k++;
        end
        if (!a) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: sample %0d not accepted, required acceptance within 100 cycles", x);
        end
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) step(cfg_n, 1'b0, '0, 1'b0, a);
    endtask

    // Monitor: every presented sum must match the queue head; pop only when consumed
    initial forever begin
        @(negedge clk);
        #3;
        if (rst && dval_u) begin
            chk("spurious_u", 32'(qu.size() != 0), 32'd1);
            if (qu.size() != 0) begin
                chk("o_u", 32'(o_u), 32'(qu[0].s));
                chk("cnt_u", 32'(cnt_u), 32'(qu[0].c));
                if (o_rdy) void'(qu.pop_front());
            end
        end
        if (rst && dval_s) begin
            chk("spurious_s", 32'(qs.size() != 0), 32'd1);
            if (qs.size() != 0) begin
                chk("o_s", 32'(o_s), 32'(qs[0].s));
                chk("cnt_s", 32'(cnt_s), 32'(qs[0].c));
                if (o_rdy) void'(qs.pop_front());
            end
        end
    end

    initial begin
        logic          a;
        logic [CW-1:0] rc;
        #1 rst = 1'b0;
        #1;
        chk("rst_dval", 32'(dval_u), 32'd0);
        chk("rst_o", 32'(o_u), 32'd0);
        chk("rst_cnt", 32'(cnt_u), 32'd0);
        chk("rst_irdy", 32'(rdy_u), 32'd0);
        chk("rst_dval_s", 32'(dval_s), 32'd0);
        @(negedge clk) rst = 1'b1;

        send(3, 1); send(3, 2); send(3, 3);
        idle(1);
        chk("t1_lat_dval", 32'(dval_u), 32'd1);
        chk("t1_o", 32'(o_u), 32'd6);
        chk("t1_cnt", 32'(cnt_u), 32'd3);
        send(3, 4); send(3, 5); send(3, 6);
        idle(1);
        chk("t1_o2", 32'(o_u), 32'd15);
        idle(1);

        repeat (4) send(4, 8'd128);
        idle(1);
        chk("t2_u", 32'(o_u), 32'd512);
        chk("t2_s", 32'(o_s), 32'h600);
        repeat (4) send(4, 8'd255);
        idle(1);
        chk("t2_u2", 32'(o_u), 32'd1020);
        chk("t2_s2", 32'(o_s), 32'h7FC);
        idle(1);

        want_rdy = 1'b0;
        send(3, 1); send(3, 2); send(3, 3);
        repeat (3) begin
            step(3, 1'b1, 8'd4, 1'b0, a);
            chk("t3_stall_acc", 32'(a), 32'd0);
            chk("t3_stall_irdy", 32'(rdy_u), 32'd0);
            chk("t3_hold", 32'(o_u), 32'd6);
        end
        want_rdy = 1'b1;
        send(3, 4); send(3, 5); send(3, 6);
        idle(1);
        chk("t3_next", 32'(o_u), 32'd15);
        idle(1);

        send(5, 10); send(5, 20);
        step(5, 1'b0, '0, 1'b1, a);
        idle(1);
        chk("t4_flush_o", 32'(o_u), 32'd30);
        chk("t4_flush_cnt", 32'(cnt_u), 32'd2);
        repeat (5) send(5, 1);
        idle(1);
        chk("t4_next", 32'(o_u), 32'd5);
        step(5, 1'b0, '0, 1'b1, a);
        idle(2);

        send(2, 7); send(4, 8);
        idle(1);
        chk("t5_first", 32'(o_u), 32'd15);
        chk("t5_first_cnt", 32'(cnt_u), 32'd2);
        send(4, 1); send(4, 2); send(4, 3); send(4, 4);
        idle(1);
        chk("t5_second", 32'(o_u), 32'd10);
        chk("t5_second_cnt", 32'(cnt_u), 32'd4);
        send(0, 9);
        idle(1);
        chk("t5_n0_o", 32'(o_u), 32'd9);
        chk("t5_n0_cnt", 32'(cnt_u), 32'd1);
        idle(1);

        send(5, 1); send(5, 2);
        #3 rst = 1'b0;
        #1;
        chk("t6_mid_dval", 32'(dval_u), 32'd0);
        chk("t6_mid_irdy", 32'(rdy_u), 32'd0);
        grp.delete(); qu.delete(); qs.delete();
        idle(1);
        @(negedge clk) rst = 1'b1;
        want_rdy = 1'b0;
        send(1, 7);
        idle(1);
        chk("t6_pend", 32'(dval_u), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_pend_dval", 32'(dval_u), 32'd0);
        chk("t6_pend_o", 32'(o_u), 32'd0);
        chk("t6_pend_cnt", 32'(cnt_u), 32'd0);
        grp.delete(); qu.delete(); qs.delete();
        idle(1);
        @(negedge clk) rst = 1'b1;
        want_rdy = 1'b1;
        send(3, 1); send(3, 1); send(3, 1);
        idle(1);
        chk("t6_restart", 32'(o_u), 32'd3);
        idle(1);

        rc = 4'd3;
        repeat (800) begin
            if ($urandom_range(0, 7) == 0) rc = CW'($urandom_range(0, 15));
            want_rdy = ($urandom_range(0, 3) != 0);
            step(rc, $urandom_range(0, 3) != 0, IW'($urandom), $urandom_range(0, 15) == 0, a);
        end
        want_rdy = 1'b1;
        idle(6);
        chk("drain_u", 32'(qu.size()), 32'd0);
        chk("drain_s", 32'(qs.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
